mp3_data_array_sram: RTL and testbench



---
 rtl/mp3_data_array_sram_pkg.sv | 21 ++
 rtl/mp3_data_array_sram.sv | 68 ++++++
 tb/tb_mp3_data_array_sram.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mp3_data_array_sram_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mp3_data_array_sram_pkg : cache data-array geometry constants   rev 1.0 |
// +-----------------------------------------------------------------------+
package mp3_data_array_sram_pkg;

   localparam int c_cache_line_bits = 256;
   localparam int c_cache_sets      = 16;
   localparam int c_byte_bits       = 8;

   function automatic int clog2_sets(input int sets);
      int n;
      n = 0;
      while ((1 << n) < sets) n++;
      return n;
   endfunction

   localparam int c_set_addr_bits = clog2_sets(c_cache_sets);

endpackage
`default_nettype wire

// File: rtl/mp3_data_array_sram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mp3_data_array_sram : 1-port sync SRAM, byte-masked writes      rev 1.0 |
// +-----------------------------------------------------------------------+
module mp3_data_array_sram
   import mp3_data_array_sram_pkg::*;
#(
   parameter int NUM_WMASKS = c_cache_line_bits / c_byte_bits,
   parameter int DATA_WIDTH = c_cache_line_bits,
   parameter int ADDR_WIDTH = c_set_addr_bits,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
   parameter int DELAY      = 0,
   parameter int VERBOSE    = 0,
   parameter int T_HOLD     = 1
) (
   input  logic                  clk0,
   input  logic                  rst0_n,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0
);

   // Timing/trace knobs only matter to behavioural models; here they are just range-checked.
   generate
      if ((NUM_WMASKS * c_byte_bits != DATA_WIDTH) || (DELAY < 0) || (T_HOLD < 0) || (VERBOSE < 0))
      begin : g_param_check
         $fatal(1, "mp3_data_array_sram: NUM_WMASKS*8 must equal DATA_WIDTH");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  w_rd_en;
   logic                  w_wr_en;

   assign w_rd_en = ~csb0 &  web0;
   assign w_wr_en = ~csb0 & ~web0;

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         for (int w = 0; w < RAM_DEPTH; w++) begin
            r_mem[w] <= '0;
         end
      end else if (w_wr_en) begin
         for (int b = 0; b < NUM_WMASKS; b++) begin
            if (wmask0[b]) begin
               r_mem[addr0][b*c_byte_bits +: c_byte_bits] <= din0[b*c_byte_bits +: c_byte_bits];
            end
         end
      end
   end

   // Output register only moves on reads; writes and idle cycles hold the last line.
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         r_dout <= '0;
      end else if (w_rd_en) begin
         r_dout <= r_mem[addr0];
      end
   end

   assign dout0 = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_mp3_data_array_sram.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mp3_data_array_sram : directed self-checking bench           rev 1.0 |
// +-----------------------------------------------------------------------+
module tb_mp3_data_array_sram;

   localparam int DW = 256;
   localparam int AW = 4;
   localparam int NM = 32;

   logic          clk0;
   logic          rst0_n;
   logic          csb0;
   logic          web0;
   logic [NM-1:0] wmask0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] din0;
   logic [DW-1:0] dout0;

   int n_checks = 0;
   int n_errors = 0;

   mp3_data_array_sram dut (
      .clk0   (clk0),
      .rst0_n (rst0_n),
      .csb0   (csb0),
      .web0   (web0),
      .wmask0 (wmask0),
      .addr0  (addr0),
      .din0   (din0),
      .dout0  (dout0)
   );

   initial clk0 = 1'b0;
   always #5 clk0 = ~clk0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      csb0 = 1'b1;
      web0 = 1'b1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [NM-1:0] m, input logic [DW-1:0] d);
      csb0 = 1'b0; web0 = 1'b0; addr0 = a; wmask0 = m; din0 = d;
      @(posedge clk0); #1;
      idle();
   endtask

   task automatic rd(input logic [AW-1:0] a);
      csb0 = 1'b0; web0 = 1'b1; addr0 = a;
      @(posedge clk0); #1;
      idle();
   endtask

   logic [DW-1:0] beef;
   logic [DW-1:0] ones;
   logic [DW-1:0] exp;

   initial begin
      beef = {8{32'hDEADBEEF}};
      ones = '1;
      rst0_n = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
      #100;
      check("reset_dout", dout0, '0);
      @(negedge clk0);
      rst0_n = 1'b1;
      @(posedge clk0); #1;

      rd(4'd3);
      check("read_after_reset", dout0, '0);

      wr(4'd5, 32'hFFFF_FFFF, beef);
      check("write_holds_dout", dout0, '0);
      rd(4'd5);
      check("full_write_read", dout0, beef);

      wr(4'd5, 32'h0000_0001, 256'hAA);
      rd(4'd5);
      exp = beef; exp[7:0] = 8'hAA;
      check("partial_low_byte", dout0, exp);

      // Deselected cycle with write-looking inputs must not touch memory or dout0.
      csb0 = 1'b1; web0 = 1'b0; addr0 = 4'd5; wmask0 = '1; din0 = ones;
      @(posedge clk0); #1;
      check("deselect_hold_dout", dout0, exp);
      rd(4'd5);
      check("deselect_no_write", dout0, exp);

      rd(4'd2);
      check("read_addr2_zero", dout0, '0);
      wr(4'd2, '1, ones);
      check("write_no_writethrough", dout0, '0);
      rd(4'd2);
      check("read_addr2_ones", dout0, ones);

      wr(4'd2, '0, '0);
      rd(4'd2);
      check("zero_mask_no_change", dout0, ones);

      wr(4'd9, 32'h8000_0000, ones);
      rd(4'd9);
      exp = '0; exp[255:248] = 8'hFF;
      check("top_byte_mask", dout0, exp);

      wr(4'd15, 32'h0000_0F00, {8{32'h1234_5678}});
      rd(4'd15);
      exp = '0; exp[95:64] = 32'h1234_5678;
      check("last_addr_partial", dout0, exp);

      // Back-to-back reads: one result per edge.
      csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd5;
      @(posedge clk0); #1;
      addr0 = 4'd2;
      exp = beef; exp[7:0] = 8'hAA;
      check("b2b_read_first", dout0, exp);
      @(posedge clk0); #1;
      idle();
      check("b2b_read_second", dout0, ones);

      wr(4'd7, '1, ones);
      rd(4'd7);
      check("read_addr7_ones", dout0, ones);

      // Async reset between edges, with a pending write held across reset edges.
      csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd8; wmask0 = '1; din0 = ones;
      #2;
      rst0_n = 1'b0;
      #1;
      check("async_reset_dout", dout0, '0);
      @(posedge clk0); @(posedge clk0);
      #2;
      idle();
      rst0_n = 1'b1;
      @(posedge clk0); #1;
      rd(4'd7);
      check("reset_cleared_addr7", dout0, '0);
      rd(4'd8);
      check("write_during_reset_dropped", dout0, '0);
      rd(4'd5);
      check("reset_cleared_addr5", dout0, '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
